relu_maxpool_stream: RTL

//  Streaming 2x2/stride-2 max-pool stage directly downstream of the conv filter bank.

---
 rtl/relu_maxpool_stream.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/relu_maxpool_stream.sv
// ---------------------------------------------------------------------------
// relu_maxpool_stream
//   Streaming 2x2 / stride-2 max-pool stage for one filter channel. Consumes a
//   FMAP_SIZE x FMAP_SIZE feature map one pixel per handshake in raster order
//   and emits the (FMAP_SIZE/2) x (FMAP_SIZE/2) pooled map in raster order
//   through a one-entry output register. An odd trailing row/column is
//   accepted and discarded.
//
//   Optional feature macro: RELU_POOL_EN
//     defined   -> output register loads max(0, pooled) (ReLU after pool)
//     undefined -> output register loads the raw signed maximum
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data / in_last valid
//   in_ready   stage accepts the input pixel this cycle (combinational)
//   in_data    conv output pixel, signed, DATA_W bits
//   in_last    marks the final pixel of the map
//   out_valid  pooled pixel available
//   out_ready  downstream accepts the pooled pixel
//   out_data   pooled pixel, signed, DATA_W bits
//   out_last   marks the final pooled pixel of the map
//   frame_err  one-cycle pulse on in_last / map-length mismatch
// ---------------------------------------------------------------------------
module relu_maxpool_stream #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned FMAP_SIZE = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              frame_err
);

   localparam int unsigned OUT_SIZE = FMAP_SIZE / 2;
   localparam int unsigned WIN      = 2 * OUT_SIZE;
   // One extra code so WIN itself is representable when FMAP_SIZE is even.
   localparam int unsigned CNT_W    = $clog2(FMAP_SIZE + 1);
   localparam int unsigned IDX_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

   localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FMAP_SIZE - 1);
   localparam logic [CNT_W-1:0] WIN_POS  = CNT_W'(WIN);
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN - 1);

   typedef enum logic [1:0] {
      EVEN_ROW  = 2'd0,
      ODD_ROW   = 2'd1,
      TRAIL_ROW = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  row_q, row_d;
   logic [CNT_W-1:0]  col_q, col_d;
   logic              err_d;

   logic [DATA_W-1:0] hreg_q;
   logic [DATA_W-1:0] lbuf [OUT_SIZE];

   logic              accept_c;
   logic              row_end_c;
   logic              final_c;
   logic              in_win_c;
   logic [IDX_W-1:0]  lb_idx_c;
   logic [DATA_W-1:0] max_h_c;
   logic [DATA_W-1:0] pool_c;
   logic [DATA_W-1:0] pool_out_c;
   logic              hreg_we_c;
   logic              lbuf_we_c;
   logic              out_load_c;

   // Signed maximum of two pixels.
   function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   // Input side can take a pixel whenever the output register is free or draining.
   assign in_ready  = !out_valid || out_ready;
   assign accept_c  = in_valid && in_ready;

   assign row_end_c = (col_q == LAST_POS);
   assign final_c   = row_end_c && (row_q == LAST_POS);
   assign in_win_c  = (col_q < WIN_POS) && (row_q < WIN_POS);
   assign lb_idx_c  = IDX_W'(col_q >> 1);

   // Horizontal pair max, then fold in the stored upper-row pair max.
   assign max_h_c   = smax(hreg_q, in_data);
   assign pool_c    = smax(lbuf[lb_idx_c], max_h_c);

`ifdef RELU_POOL_EN
   assign pool_out_c = pool_c[DATA_W-1] ? '0 : pool_c;
`else
   assign pool_out_c = pool_c;
`endif

   // Datapath strobes; the row bound in in_win_c keeps TRAIL_ROW pixels out.
   assign hreg_we_c  = accept_c && in_win_c && !col_q[0];
   assign lbuf_we_c  = accept_c && in_win_c &&  col_q[0] && (state_q == EVEN_ROW);
   assign out_load_c = accept_c && in_win_c &&  col_q[0] && (state_q == ODD_ROW);

   // Next-state / counter logic, advancing only on an accepted pixel.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      err_d   = 1'b0;
      if (accept_c) begin
         if (in_last && !final_c) begin
            // Early in_last: restart the map at the next pixel.
            err_d   = 1'b1;
            row_d   = '0;
            col_d   = '0;
            state_d = EVEN_ROW;
         end else if (final_c) begin
            // Final pixel wraps whether or not in_last came with it.
            err_d   = !in_last;
            row_d   = '0;
            col_d   = '0;
            state_d = EVEN_ROW;
         end else if (row_end_c) begin
            col_d = '0;
            row_d = row_q + CNT_W'(1);
            case (state_q)
               EVEN_ROW: state_d = ODD_ROW;
               ODD_ROW:  state_d = (row_q == WIN_LAST) ? TRAIL_ROW : EVEN_ROW;
               default:  state_d = TRAIL_ROW;
            endcase
         end else begin
            col_d = col_q + CNT_W'(1);
         end
      end
   end

   // State, position counters and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EVEN_ROW;
         row_q     <= '0;
         col_q     <= '0;
         frame_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         frame_err <= err_d;
      end
   end

   // Left pixel of the current horizontal pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hreg_q <= '0;
      end else if (hreg_we_c) begin
         hreg_q <= in_data;
      end
   end

   // Line buffer of upper-row pair maxima; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (lbuf_we_c) begin
         lbuf[lb_idx_c] <= max_h_c;
      end
   end

   // One-entry output register; holds while stalled by out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (out_load_c) begin
         out_valid <= 1'b1;
         out_data  <= pool_out_c;
         out_last  <= (row_q == WIN_LAST) && (col_q == WIN_LAST);
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule
